// File: rtl/i2c_master_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_master_arbiter
//
// Purpose:
//   Single-master I2C engine shared by two requesters. A requester raises
//   req[n] with its slave address, direction and write byte; the arbiter
//   picks an owner while idle, latches that owner's operands, and runs one
//   complete single-byte transaction: START, address+rw, ACK, one data byte
//   (written or read), ACK/NACK, STOP. The owner then sees a one-cycle
//   done[n] pulse with nack and rdata valid alongside it.
//
//   Every SCL bit is split into four phases of CLK_DIV clk cycles each:
//     P0 scl=0 (SDA changes), P1 scl=1, P2 scl=1 (SDA sampled at end), P3 scl=0.
//
// Configuration:
//   I2C_ARB_FIXED_PRIO_EN  when defined, req0 always wins a tie (fixed
//                          priority). When undefined (default), ties are
//                          settled round-robin, favouring req0 after reset.
//
// Parameters:
//   CLK_DIV   clk cycles per quarter SCL bit, legal range 2..65535.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   req     in   [1:0]  per-requester request, held until done
//   addr    in   [13:0] 7-bit slave address per requester ([6:0] req0, [13:7] req1)
//   rw      in   [1:0]  per-requester direction (1 = read)
//   wdata   in   [15:0] write byte per requester ([7:0] req0, [15:8] req1)
//   gnt     out  [1:0]  one-hot owner of the running transaction
//   done    out  [1:0]  one-cycle completion pulse to the owner
//   nack    out  address or write data not acknowledged (valid with done)
//   rdata   out  [7:0]  read byte (valid with done on a read)
//   busy    out  high from grant until done inclusive
//   scl     out  push-pull I2C clock
//   sda     io   open-drain I2C data, only ever pulled low or released
// ---------------------------------------------------------------------------
module i2c_master_arbiter #(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [13:0] addr,
    input  logic [1:0]  rw,
    input  logic [15:0] wdata,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic        nack,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        scl,
    inout  wire         sda
);

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RD_NACK,
        STOP,
        DONE
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    // Sequencer state and its next-state values
    state_t      state_q, state_d;
    logic [15:0] divCnt_q, divCnt_d;
    logic [1:0]  phase_q, phase_d;
    logic [2:0]  bitCnt_q, bitCnt_d;

    // Operands latched from the winning requester at grant time
    logic [6:0]  addrLat_q;
    logic        rwLat_q;
    logic [7:0]  wdataLat_q;

    // Bits collected from the bus
    logic [7:0]  rxShift_q;
    logic        nackFlag_q;

    // Registered outputs
    logic [1:0]  gnt_q;
    logic [1:0]  done_q;
    logic        nack_q;
    logic [7:0]  rdata_q;
    logic        busy_q;
    logic        scl_q;
    logic        sdaLow_q;

    logic [1:0]  winner;
    logic        tick;
    logic        sdaIn;

`ifndef I2C_ARB_FIXED_PRIO_EN
    // Set when req1 should win the next tie
    logic        favour1_q;
`endif

    assign tick  = (divCnt_q == DIV_LAST);
    assign sdaIn = sda;

    // Choose who would be granted if the engine is idle this cycle. A lone
    // request always wins; only a tie consults the priority scheme.
    always_comb begin
        winner = 2'b00;
`ifdef I2C_ARB_FIXED_PRIO_EN
        if (req[0]) begin
            winner = 2'b01;
        end else if (req[1]) begin
            winner = 2'b10;
        end
`else
        if (req == 2'b11) begin
            winner = favour1_q ? 2'b10 : 2'b01;
        end else begin
            winner = req;
        end
`endif
    end

    // Next-state sequencing. IDLE and DONE move on plain clock edges (grant
    // and the single DONE cycle); every other state only advances on a
    // phase tick, and changes state after the fourth phase of a bit.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bitCnt_d = bitCnt_q;
        divCnt_d = divCnt_q + 16'd1;
        unique case (state_q)
            IDLE: begin
                divCnt_d = 16'd0;
                phase_d  = 2'd0;
                bitCnt_d = 3'd0;
                if (winner != 2'b00) begin
                    state_d = START;
                end
            end
            DONE: begin
                divCnt_d = 16'd0;
                phase_d  = 2'd0;
                state_d  = IDLE;
            end
            default: begin
                if (tick) begin
                    divCnt_d = 16'd0;
                    phase_d  = phase_q + 2'd1;
                    if (phase_q == 2'd3) begin
                        case (state_q)
                            START: begin
                                state_d  = ADDR;
                                bitCnt_d = 3'd0;
                            end
                            ADDR: begin
                                bitCnt_d = bitCnt_q + 3'd1;
                                if (bitCnt_q == 3'd7) begin
                                    state_d = ADDR_ACK;
                                end
                            end
                            ADDR_ACK: begin
                                bitCnt_d = 3'd0;
                                if (nackFlag_q) begin
                                    state_d = STOP;
                                end else if (rwLat_q) begin
                                    state_d = RDATA;
                                end else begin
                                    state_d = WDATA;
                                end
                            end
                            WDATA: begin
                                bitCnt_d = bitCnt_q + 3'd1;
                                if (bitCnt_q == 3'd7) begin
                                    state_d = WDATA_ACK;
                                end
                            end
                            RDATA: begin
                                bitCnt_d = bitCnt_q + 3'd1;
                                if (bitCnt_q == 3'd7) begin
                                    state_d = RD_NACK;
                                end
                            end
                            WDATA_ACK, RD_NACK: state_d = STOP;
                            STOP:               state_d = DONE;
                            default:            state_d = state_q;
                        endcase
                    end
                end
            end
        endcase
    end

    // SCL level for a given state/phase. Data and ACK bits share the
    // low-high-high-low shape; STOP raises SCL from its second phase on.
    function automatic logic sclFor(input state_t s, input logic [1:0] p);
        case (s)
            ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RD_NACK:
                return (p == 2'd1) || (p == 2'd2);
            STOP:
                return (p != 2'd0);
            default:
                return 1'b1;
        endcase
    endfunction

    // Whether the master pulls SDA low for a given state/phase. START pulls
    // low in its second half (SDA falls while SCL is high); STOP holds low
    // for its first half and releases while SCL is high. ACK and read bits
    // always leave the line to the slave.
    function automatic logic sdaLowFor(input state_t     s,
                                       input logic [1:0] p,
                                       input logic [2:0] b,
                                       input logic [7:0] aByte,
                                       input logic [7:0] dByte);
        case (s)
            START:   return p[1];
            ADDR:    return !aByte[3'd7 - b];
            WDATA:   return !dByte[3'd7 - b];
            STOP:    return !p[1];
            default: return 1'b0;
        endcase
    endfunction

    // Main register block. Bus outputs are registered from the next state
    // so SCL/SDA change exactly on the phase boundary. Operands are latched
    // at grant so later changes on the request inputs cannot disturb the
    // transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            divCnt_q   <= 16'd0;
            phase_q    <= 2'd0;
            bitCnt_q   <= 3'd0;
            addrLat_q  <= 7'd0;
            rwLat_q    <= 1'b0;
            wdataLat_q <= 8'd0;
            rxShift_q  <= 8'd0;
            nackFlag_q <= 1'b0;
            gnt_q      <= 2'b00;
            done_q     <= 2'b00;
            nack_q     <= 1'b0;
            rdata_q    <= 8'h00;
            busy_q     <= 1'b0;
            scl_q      <= 1'b1;
            sdaLow_q   <= 1'b0;
`ifndef I2C_ARB_FIXED_PRIO_EN
            favour1_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            divCnt_q <= divCnt_d;
            phase_q  <= phase_d;
            bitCnt_q <= bitCnt_d;
            scl_q    <= sclFor(state_d, phase_d);
            sdaLow_q <= sdaLowFor(state_d, phase_d, bitCnt_d,
                                  {addrLat_q, rwLat_q}, wdataLat_q);
            done_q   <= 2'b00;

            if (state_q == IDLE && winner != 2'b00) begin
                gnt_q      <= winner;
                busy_q     <= 1'b1;
                nack_q     <= 1'b0;
                nackFlag_q <= 1'b0;
                rxShift_q  <= 8'd0;
                addrLat_q  <= winner[1] ? addr[13:7]  : addr[6:0];
                rwLat_q    <= winner[1] ? rw[1]       : rw[0];
                wdataLat_q <= winner[1] ? wdata[15:8] : wdata[7:0];
`ifndef I2C_ARB_FIXED_PRIO_EN
                // Whoever just won yields the next tie to the other side
                favour1_q  <= winner[0];
`endif
            end

            // Sample the bus at the end of P2, while SCL is still high
            if (tick && phase_q == 2'd2) begin
                case (state_q)
                    ADDR_ACK, WDATA_ACK: nackFlag_q <= sdaIn;
                    RDATA:               rxShift_q  <= {rxShift_q[6:0], sdaIn};
                    default: ;
                endcase
            end

            if (state_d == DONE && state_q != DONE) begin
                done_q <= gnt_q;
                nack_q <= nackFlag_q;
                if (rwLat_q) begin
                    rdata_q <= rxShift_q;
                end
            end

            if (state_q == DONE) begin
                gnt_q  <= 2'b00;
                busy_q <= 1'b0;
            end
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign nack  = nack_q;
    assign rdata = rdata_q;
    assign busy  = busy_q;
    assign scl   = scl_q;
    assign sda   = sdaLow_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
`timescale 1ns/1ps
module tb_i2c_master_arbiter;

    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [13:0] addr;
    logic [1:0]  rw;
    logic [15:0] wdata;
    wire  [1:0]  gnt;
    wire  [1:0]  done;
    wire         nack;
    wire  [7:0]  rdata;
    wire         busy;
    wire         scl;
    wire         sda;
    logic        slaveLow;

    int testsRun = 0;
    int testsFailed = 0;

    // One transaction vector: requester inputs, slave behaviour, expectations
    typedef struct {
        logic [1:0]  reqSel;
        logic [6:0]  addr;
        logic        rw;
        logic [7:0]  wdata;
        logic        ackAddr;
        logic        ackData;
        logic [7:0]  rdByte;
        logic        dropEarly;
        int          expCycles;
        logic        expNack;
        logic        chkRd;
        logic [7:0]  expRdata;
        int          expNb;
        logic [18:0] expBits;
    } vec_t;

    vec_t vecs[5];

    // Bus with pull-up; the slave model only ever pulls low
    pullup (sda);
    assign sda = slaveLow ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_master_arbiter #(.CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .addr  (addr),
        .rw    (rw),
        .wdata (wdata),
        .gnt   (gnt),
        .done  (done),
        .nack  (nack),
        .rdata (rdata),
        .busy  (busy),
        .scl   (scl),
        .sda   (sda)
    );

    // Guard against a hung run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Slave behaviour by phase index counted from the grant edge:
    // phases 36..39 address ACK, 40..71 read data bits, 72..75 data ACK.
    function automatic logic slaveDrive(input vec_t v, input int ph);
        int bi;
        if (ph >= 36 && ph < 40) return v.ackAddr;
        if (v.ackAddr && v.rw && ph >= 40 && ph < 72) begin
            bi = 7 - (ph - 40) / 4;
            return !v.rdByte[bi[2:0]];
        end
        if (v.ackAddr && !v.rw && ph >= 72 && ph < 76) return v.ackData;
        return 1'b0;
    endfunction

    // Runs one whole transaction from a vector and checks the outcome
    task automatic applyStimulus(input vec_t v, input int idx);
        int          el;
        int          waitN;
        int          nb;
        int          doneAt;
        logic        prevScl;
        logic [18:0] bits;
        logic [1:0]  doneVal;
        logic        nackSeen;
        logic [7:0]  rdSeen;

        // The other requester's fields carry inverted values so a wrong
        // operand selection shows up on the bus
        if (v.reqSel == 2'b10) begin
            addr  = {v.addr, ~v.addr};
            rw    = {v.rw, ~v.rw};
            wdata = {v.wdata, ~v.wdata};
        end else begin
            addr  = {~v.addr, v.addr};
            rw    = {~v.rw, v.rw};
            wdata = {~v.wdata, v.wdata};
        end
        req = v.reqSel;

        waitN = 0;
        while (gnt == 2'b00 && waitN < 50) begin
            @(negedge clk);
            waitN++;
        end
        checkOutput($sformatf("v%0d grant", idx), {30'd0, gnt}, {30'd0, v.reqSel});
        checkOutput($sformatf("v%0d grantLatency", idx), waitN, 1);
        checkOutput($sformatf("v%0d busyAtGrant", idx), {31'd0, busy}, 1);

        el       = 0;
        nb       = 0;
        bits     = '0;
        prevScl  = scl;
        doneAt   = -1;
        doneVal  = 2'b00;
        nackSeen = 1'b0;
        rdSeen   = 8'h00;
        while (doneAt < 0 && el < 1000) begin
            slaveLow = slaveDrive(v, el / CLK_DIV);
            if (v.dropEarly && el == 50) begin
                req   = 2'b00;
                addr  = '0;
                rw    = '0;
                wdata = '0;
            end
            @(negedge clk);
            el++;
            if (scl && !prevScl) begin
                if (nb < 19) bits[18 - nb] = sda;
                nb++;
            end
            prevScl = scl;
            if (done != 2'b00) begin
                doneAt   = el;
                doneVal  = done;
                nackSeen = nack;
                rdSeen   = rdata;
            end
        end
        slaveLow = 1'b0;
        req      = 2'b00;

        checkOutput($sformatf("v%0d doneCycles", idx), doneAt, v.expCycles);
        checkOutput($sformatf("v%0d doneOwner", idx), {30'd0, doneVal}, {30'd0, v.reqSel});
        checkOutput($sformatf("v%0d nack", idx), {31'd0, nackSeen}, {31'd0, v.expNack});
        checkOutput($sformatf("v%0d sclRises", idx), nb, v.expNb);
        checkOutput($sformatf("v%0d sdaBits", idx), {13'd0, bits}, {13'd0, v.expBits});
        if (v.chkRd) checkOutput($sformatf("v%0d rdata", idx), {24'd0, rdSeen}, {24'd0, v.expRdata});

        @(negedge clk);
        checkOutput($sformatf("v%0d idleGap", idx), {27'd0, done, gnt, busy}, 0);
    endtask

    initial begin
        int   el;
        int   w;
        logic [1:0] expG;

        vecs[0] = '{reqSel:2'b01, addr:7'h50, rw:1'b0, wdata:8'hA5, ackAddr:1'b1, ackData:1'b1,
                    rdByte:8'h00, dropEarly:1'b0, expCycles:320, expNack:1'b0, chkRd:1'b0,
                    expRdata:8'h00, expNb:19, expBits:19'b1010000001010010100};
        vecs[1] = '{reqSel:2'b10, addr:7'h3C, rw:1'b1, wdata:8'h00, ackAddr:1'b1, ackData:1'b0,
                    rdByte:8'h5A, dropEarly:1'b0, expCycles:320, expNack:1'b0, chkRd:1'b1,
                    expRdata:8'h5A, expNb:19, expBits:19'b0111100100101101010};
        vecs[2] = '{reqSel:2'b01, addr:7'h11, rw:1'b0, wdata:8'hFF, ackAddr:1'b0, ackData:1'b0,
                    rdByte:8'h00, dropEarly:1'b0, expCycles:176, expNack:1'b1, chkRd:1'b0,
                    expRdata:8'h00, expNb:10, expBits:19'b0010001010000000000};
        vecs[3] = '{reqSel:2'b10, addr:7'h2A, rw:1'b0, wdata:8'h3C, ackAddr:1'b1, ackData:1'b0,
                    rdByte:8'h00, dropEarly:1'b1, expCycles:320, expNack:1'b1, chkRd:1'b0,
                    expRdata:8'h00, expNb:19, expBits:19'b0101010000011110010};
        vecs[4] = '{reqSel:2'b01, addr:7'h7F, rw:1'b1, wdata:8'h00, ackAddr:1'b1, ackData:1'b0,
                    rdByte:8'h81, dropEarly:1'b0, expCycles:320, expNack:1'b0, chkRd:1'b1,
                    expRdata:8'h81, expNb:19, expBits:19'b1111111101000000110};

        rst      = 1'b1;
        req      = 2'b00;
        addr     = '0;
        rw       = '0;
        wdata    = '0;
        slaveLow = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset scl", {31'd0, scl}, 1);
        checkOutput("reset sda", {31'd0, sda}, 1);
        checkOutput("reset gnt", {30'd0, gnt}, 0);
        checkOutput("reset done", {30'd0, done}, 0);
        checkOutput("reset nack", {31'd0, nack}, 0);
        checkOutput("reset rdata", {24'd0, rdata}, 0);
        checkOutput("reset busy", {31'd0, busy}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("noReq busy", {31'd0, busy}, 0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Reset in the middle of address bit 5: abort at once, no STOP
        addr  = {7'h00, 7'h50};
        rw    = 2'b00;
        wdata = 16'h00A5;
        req   = 2'b01;
        w = 0;
        while (gnt == 2'b00 && w < 50) begin
            @(negedge clk);
            w++;
        end
        el = 0;
        while (el < 98) begin
            @(negedge clk);
            el++;
        end
        checkOutput("resetMid busyBefore", {31'd0, busy}, 1);
        checkOutput("resetMid sclBefore", {31'd0, scl}, 0);
        rst = 1'b1;
        req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("resetMid scl", {31'd0, scl}, 1);
        checkOutput("resetMid sda", {31'd0, sda}, 1);
        checkOutput("resetMid busy", {31'd0, busy}, 0);
        checkOutput("resetMid gnt", {30'd0, gnt}, 0);
        checkOutput("resetMid rdata", {24'd0, rdata}, 0);
        @(negedge clk);
        applyStimulus(vecs[0], 10);

        // Both requesters held high from a fresh reset
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        addr  = {7'h11, 7'h11};
        rw    = 2'b00;
        wdata = '0;
        req   = 2'b11;
        for (int k = 0; k < 4; k++) begin
`ifdef I2C_ARB_FIXED_PRIO_EN
            expG = 2'b01;
`else
            expG = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
            w = 0;
            while (gnt == 2'b00 && w < 50) begin
                @(negedge clk);
                w++;
            end
            checkOutput($sformatf("rr%0d grant", k), {30'd0, gnt}, {30'd0, expG});
            el = 0;
            while (done == 2'b00 && el < 500) begin
                @(negedge clk);
                el++;
            end
            checkOutput($sformatf("rr%0d doneOwner", k), {30'd0, done}, {30'd0, expG});
            checkOutput($sformatf("rr%0d doneCycles", k), el, 176);
            @(negedge clk);
            checkOutput($sformatf("rr%0d idleGap", k), {31'd0, busy}, 0);
        end
        req = 2'b00;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
